// File: rtl/sprite_motion_engine.sv
// Multi-sprite position engine: one pass per frame tick walks every sprite, queries the
// valid-move detector at block centres and applies STEP-pixel motion with tunnel wrap.
module sprite_motion_engine #(
  parameter int unsigned                     NUM_SPRITES  = 5,
  parameter int unsigned                     X_W          = 11,
  parameter int unsigned                     Y_W          = 10,
  parameter int unsigned                     BLOCK_PITCH  = 15,
  parameter int unsigned                     STEP         = 3,
  parameter logic [X_W-1:0]                  X_MIN        = X_W'(10),
  parameter logic [X_W-1:0]                  X_MAX        = X_W'(415),
  parameter logic [NUM_SPRITES*X_W-1:0]      RESET_X_FLAT = {NUM_SPRITES{X_W'(10)}},
  parameter logic [NUM_SPRITES*Y_W-1:0]      RESET_Y_FLAT = {NUM_SPRITES{Y_W'(10)}}
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               frame_tick,
  input  logic [4*NUM_SPRITES-1:0]           dir_req_flat,
  output logic                               q_valid,
  output logic [X_W-1:0]                     q_x,
  output logic [Y_W-1:0]                     q_y,
  input  logic                               resp_valid,
  input  logic [3:0]                         resp_moves,
  output logic [X_W*NUM_SPRITES-1:0]         pos_x_flat,
  output logic [Y_W*NUM_SPRITES-1:0]         pos_y_flat,
  output logic [4*NUM_SPRITES-1:0]           cur_dir_flat,
  output logic                               update_done,
  output logic                               overrun
);

  localparam int unsigned IW = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
  localparam int unsigned PW = (BLOCK_PITCH > 1) ? $clog2(BLOCK_PITCH) : 1;

  localparam logic [3:0] DIR_R = 4'b0001;
  localparam logic [3:0] DIR_U = 4'b0010;
  localparam logic [3:0] DIR_D = 4'b0100;
  localparam logic [3:0] DIR_L = 4'b1000;

  typedef enum logic [2:0] {StIdle, StLoad, StQuery, StWait, StApply, StDone} state_e;

  state_e                 state;
  logic [IW-1:0]          idx;
  logic [4*NUM_SPRITES-1:0] req_shadow;
  logic [3:0]             moves;
  logic [X_W-1:0]         pos_x [NUM_SPRITES];
  logic [Y_W-1:0]         pos_y [NUM_SPRITES];
  logic [3:0]             dir   [NUM_SPRITES];
  logic [PW-1:0]          prog  [NUM_SPRITES];

  logic [3:0]     req, cur, new_dir;
  logic [X_W-1:0] cx, nx;
  logic [Y_W-1:0] cy, ny;
  logic [PW-1:0]  cp, np;
  logic [PW:0]    psum;
  logic           req_onehot, tunnel;

  // Next-state of the sprite currently selected by idx, consumed in StApply.
  always_comb begin
    req        = req_shadow[idx*4 +: 4];
    cur        = dir[idx];
    cx         = pos_x[idx];
    cy         = pos_y[idx];
    cp         = prog[idx];
    req_onehot = $onehot(req);
    new_dir    = cur;
    nx         = cx;
    ny         = cy;
    np         = cp;
    psum       = '0;
    if (cp == '0) begin
      if (req_onehot && ((req & moves) != 4'b0000)) begin
        new_dir = req;
      end else if ((cur & moves) != 4'b0000) begin
        new_dir = cur;
      end else begin
        new_dir = 4'b0000;
      end
    end else if (req_onehot && (req == {cur[0], cur[1], cur[2], cur[3]})) begin
      // Bit-reversal of a one-hot direction is its opposite.
      new_dir = req;
      np      = PW'(BLOCK_PITCH) - cp;
    end
    tunnel = (cp == '0) && (((new_dir == DIR_R) && (cx == X_MAX)) ||
                            ((new_dir == DIR_L) && (cx == X_MIN)));
    if (tunnel) begin
      nx = (new_dir == DIR_R) ? X_MIN : X_MAX;
    end else if (new_dir != 4'b0000) begin
      unique case (new_dir)
        DIR_R:   nx = cx + X_W'(STEP);
        DIR_L:   nx = cx - X_W'(STEP);
        DIR_U:   ny = cy + Y_W'(STEP);
        DIR_D:   ny = cy - Y_W'(STEP);
        default: ;
      endcase
      psum = {1'b0, np} + (PW+1)'(STEP);
      if (psum >= (PW+1)'(BLOCK_PITCH)) begin
        psum = psum - (PW+1)'(BLOCK_PITCH);
      end
      np = psum[PW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= StIdle;
      idx         <= '0;
      req_shadow  <= '0;
      moves       <= '0;
      q_valid     <= 1'b0;
      q_x         <= '0;
      q_y         <= '0;
      update_done <= 1'b0;
      overrun     <= 1'b0;
      for (int s = 0; s < NUM_SPRITES; s++) begin
        pos_x[s] <= RESET_X_FLAT[s*X_W +: X_W];
        pos_y[s] <= RESET_Y_FLAT[s*Y_W +: Y_W];
        dir[s]   <= 4'b0000;
        prog[s]  <= '0;
      end
    end else begin
      q_valid     <= 1'b0;
      update_done <= 1'b0;
      overrun     <= frame_tick && (state != StIdle);
      case (state)
        StIdle: begin
          if (frame_tick) begin
            req_shadow <= dir_req_flat;
            idx        <= '0;
            state      <= StLoad;
          end
        end
        StLoad: begin
          if (prog[idx] == '0) begin
            q_valid <= 1'b1;
            q_x     <= pos_x[idx];
            q_y     <= pos_y[idx];
            state   <= StQuery;
          end else begin
            state <= StApply;
          end
        end
        StQuery: state <= StWait;
        StWait: begin
          if (resp_valid) begin
            moves <= resp_moves;
            state <= StApply;
          end
        end
        StApply: begin
          pos_x[idx] <= nx;
          pos_y[idx] <= ny;
          dir[idx]   <= new_dir;
          prog[idx]  <= np;
          if (idx == IW'(NUM_SPRITES - 1)) begin
            update_done <= 1'b1;
            state       <= StDone;
          end else begin
            idx   <= idx + IW'(1);
            state <= StLoad;
          end
        end
        StDone:  state <= StIdle;
        default: state <= StIdle;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_flat
    assign pos_x_flat[g*X_W +: X_W] = pos_x[g];
    assign pos_y_flat[g*Y_W +: Y_W] = pos_y[g];
    assign cur_dir_flat[g*4 +: 4]   = dir[g];
  end

endmodule

// File: tb/tb_sprite_motion_engine.sv
// Randomized scoreboard bench for sprite_motion_engine with a grid-level reference model
// and a scripted valid-move responder.
module tb_sprite_motion_engine;

  localparam int NS   = 3;
  localparam int XW   = 11;
  localparam int YW   = 10;
  localparam int REQW = 4 * NS;
  localparam int PITCH = 15;
  localparam int STP  = 3;
  localparam int XLO  = 10;
  localparam int XHI  = 415;
  localparam int YLO  = 10;
  localparam int YHI  = 310;
  localparam logic [NS*XW-1:0] RX = {11'd205, 11'd415, 11'd10};
  localparam logic [NS*YW-1:0] RY = {10'd100, 10'd40, 10'd10};

  localparam logic [3:0] R = 4'b0001, U = 4'b0010, D = 4'b0100, L = 4'b1000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic frame_tick = 1'b0;
  logic [REQW-1:0] dir_req_flat = '0;
  logic q_valid;
  logic [XW-1:0] q_x;
  logic [YW-1:0] q_y;
  logic resp_valid = 1'b0;
  logic [3:0] resp_moves = 4'b0000;
  logic [XW*NS-1:0] pos_x_flat;
  logic [YW*NS-1:0] pos_y_flat;
  logic [REQW-1:0] cur_dir_flat;
  logic update_done;
  logic overrun;

  sprite_motion_engine #(
    .NUM_SPRITES (NS),
    .X_W         (XW),
    .Y_W         (YW),
    .BLOCK_PITCH (PITCH),
    .STEP        (STP),
    .X_MIN       (11'd10),
    .X_MAX       (11'd415),
    .RESET_X_FLAT(RX),
    .RESET_Y_FLAT(RY)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .frame_tick  (frame_tick),
    .dir_req_flat(dir_req_flat),
    .q_valid     (q_valid),
    .q_x         (q_x),
    .q_y         (q_y),
    .resp_valid  (resp_valid),
    .resp_moves  (resp_moves),
    .pos_x_flat  (pos_x_flat),
    .pos_y_flat  (pos_y_flat),
    .cur_dir_flat(cur_dir_flat),
    .update_done (update_done),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [3:0] moves; int lat; } plan_t;
  typedef struct { logic [XW-1:0] x; logic [YW-1:0] y; } qry_t;
  typedef struct {
    int tick; int len;
    logic [XW*NS-1:0] xs; logic [YW*NS-1:0] ys; logic [REQW-1:0] ds;
  } snap_t;

  plan_t plan_q[$];
  qry_t  qry_q[$];
  snap_t snap_q[$];

  int vectors = 0;
  int miscompares = 0;
  int done_cnt = 0;
  int ovr_seen = 0;
  int ovr_exp = 0;
  bit manual = 1'b0;

  int mx[NS], my[NS], mp[NS];
  logic [3:0] md[NS];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] opposite(input logic [3:0] d);
    case (d)
      R: return L;
      L: return R;
      U: return D;
      D: return U;
      default: return 4'b0000;
    endcase
  endfunction

  task automatic model_reset();
    for (int s = 0; s < NS; s++) begin
      mx[s] = int'(RX[s*XW +: XW]);
      my[s] = int'(RY[s*YW +: YW]);
      md[s] = 4'b0000;
      mp[s] = 0;
    end
  endtask

  // Valid-move detector stand-in: answers each query from the plan after its latency.
  initial begin
    plan_t p;
    forever begin
      @(negedge clk);
      if (q_valid && !manual) begin
        check("resp_plan_available", 64'(plan_q.size() != 0), 64'd1);
        if (plan_q.size() != 0) p = plan_q.pop_front();
        else begin p.moves = 4'b0000; p.lat = 1; end
        repeat (p.lat) @(posedge clk);
        #1 resp_valid = 1'b1; resp_moves = p.moves;
        @(posedge clk);
        #1 resp_valid = 1'b0; resp_moves = 4'($urandom);
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents a query or finishes a pass.
  initial begin
    qry_t  eq;
    snap_t es;
    forever begin
      @(negedge clk);
      if (!rst && overrun) ovr_seen++;
      if (!rst && q_valid) begin
        check("query_expected", 64'(qry_q.size() != 0), 64'd1);
        if (qry_q.size() != 0) begin
          eq = qry_q.pop_front();
          check("q_x", 64'(q_x), 64'(eq.x));
          check("q_y", 64'(q_y), 64'(eq.y));
        end
      end
      if (!rst && update_done) begin
        done_cnt++;
        check("done_expected", 64'(snap_q.size() != 0), 64'd1);
        if (snap_q.size() != 0) begin
          es = snap_q.pop_front();
          check("pass_len", 64'(cyc - es.tick), 64'(es.len));
          check("pos_x_flat", 64'(pos_x_flat), 64'(es.xs));
          check("pos_y_flat", 64'(pos_y_flat), 64'(es.ys));
          check("cur_dir_flat", 64'(cur_dir_flat), 64'(es.ds));
        end
      end
    end
  end

  task automatic wait_done(input int start);
    bit ok = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk);
      if (done_cnt != start) begin ok = 1'b1; break; end
    end
    check("pass_completes", 64'(ok), 64'd1);
  endtask

  task automatic do_pass(input bit with_overrun);
    logic [REQW-1:0] reqs;
    logic [3:0] r, allow;
    plan_t p;
    qry_t q;
    snap_t sn;
    int len, start, k;
    for (int s = 0; s < NS; s++) begin
      k = int'($urandom_range(0, 7));
      case (k)
        0, 1, 2, 3: r = 4'b0001 << k;
        4:          r = opposite(md[s]);
        5:          r = 4'b0000;
        6:          r = ($urandom_range(0, 1) != 0) ? 4'b0110 : 4'b1111;
        default:    r = md[s];
      endcase
      reqs[s*4 +: 4] = r;
    end
    len = 1;
    for (int s = 0; s < NS; s++) begin
      r = reqs[s*4 +: 4];
      if (mp[s] == 0) begin
        allow = R | L;
        if (my[s] < YHI) allow = allow | U;
        if (my[s] > YLO) allow = allow | D;
        p.lat = int'($urandom_range(1, 4));
        p.moves = 4'($urandom) | (($urandom_range(0, 1) != 0) ? r : 4'b0000)
                | (($urandom_range(0, 1) != 0) ? md[s] : 4'b0000);
        p.moves = p.moves & allow;
        plan_q.push_back(p);
        q.x = XW'(mx[s]);
        q.y = YW'(my[s]);
        qry_q.push_back(q);
        len += 3 + p.lat;
        if ($countones(r) == 1 && (r & p.moves) != 4'b0000) md[s] = r;
        else if ((md[s] & p.moves) == 4'b0000) md[s] = 4'b0000;
        if (md[s] == R && mx[s] == XHI) begin mx[s] = XLO; continue; end
        if (md[s] == L && mx[s] == XLO) begin mx[s] = XHI; continue; end
      end else begin
        len += 2;
        if ($countones(r) == 1 && r == opposite(md[s])) begin
          md[s] = r;
          mp[s] = PITCH - mp[s];
        end
      end
      if (md[s] != 4'b0000) begin
        case (md[s])
          R: mx[s] += STP;
          L: mx[s] -= STP;
          U: my[s] += STP;
          D: my[s] -= STP;
          default: ;
        endcase
        mp[s] = (mp[s] + STP) % PITCH;
      end
    end
    sn.len = len;
    for (int s = 0; s < NS; s++) begin
      sn.xs[s*XW +: XW] = XW'(mx[s]);
      sn.ys[s*YW +: YW] = YW'(my[s]);
      sn.ds[s*4 +: 4]   = md[s];
    end
    start = done_cnt;
    @(posedge clk);
    #1 sn.tick = cyc; snap_q.push_back(sn); dir_req_flat = reqs; frame_tick = 1'b1;
    @(posedge clk);
    #1 frame_tick = 1'b0; dir_req_flat = REQW'($urandom);
    if (with_overrun) begin
      repeat (2) @(posedge clk);
      #1 frame_tick = 1'b1;
      @(posedge clk);
      #1 frame_tick = 1'b0;
      ovr_exp++;
    end
    wait_done(start);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  initial begin
    bit seen;
    int start;
    qry_t q;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_pos_x", 64'(pos_x_flat), 64'(RX));
    check("reset_pos_y", 64'(pos_y_flat), 64'(RY));
    check("reset_dir", 64'(cur_dir_flat), 64'd0);
    check("reset_q_valid", 64'(q_valid), 64'd0);
    check("reset_update_done", 64'(update_done), 64'd0);
    check("reset_overrun", 64'(overrun), 64'd0);

    for (int n = 0; n < 80; n++) do_pass((n % 6) == 2);

    // Reset in the middle of WAIT must abort the pass and ignore the late response.
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    manual = 1'b1;
    q.x = RX[XW-1:0];
    q.y = RY[YW-1:0];
    qry_q.push_back(q);
    start = done_cnt;
    #0 dir_req_flat = {NS{R}}; frame_tick = 1'b1;
    @(posedge clk);
    #1 frame_tick = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (q_valid) begin seen = 1'b1; break; end
    end
    check("abort_query_seen", 64'(seen), 64'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("abort_pos_x", 64'(pos_x_flat), 64'(RX));
    check("abort_pos_y", 64'(pos_y_flat), 64'(RY));
    check("abort_dir", 64'(cur_dir_flat), 64'd0);
    resp_valid = 1'b1; resp_moves = R;
    @(posedge clk);
    #1 resp_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("late_resp_pos_x", 64'(pos_x_flat), 64'(RX));
    check("late_resp_dir", 64'(cur_dir_flat), 64'd0);
    check("abort_no_done", 64'(done_cnt), 64'(start));
    manual = 1'b0;

    for (int n = 0; n < 6; n++) do_pass(n == 3);

    repeat (10) @(posedge clk);
    check("overrun_pulses", 64'(ovr_seen), 64'(ovr_exp));
    check("queries_drained", 64'(qry_q.size()), 64'd0);
    check("plans_drained", 64'(plan_q.size()), 64'd0);
    check("snaps_drained", 64'(snap_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
